// File: rtl/apx_fp_pkg.sv
// Shared definitions for the approximate floating-point arithmetic units.
package apx_fp_pkg;

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        UNPACK,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        PUT_Z
    } fp_state_t;

    // Guard, round and sticky bits carried below the significand
    localparam int GRS_W = 3;

    // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set
    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r = r | (64'd1 << (man_w - 1));
        return r;
    endfunction

endpackage

// File: rtl/apx_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module apx_lzc #(
    parameter int WIDTH = 27,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Scan upward so the highest set bit decides the final count
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) count = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/apx_fp_adder_cfg.sv
// Multi-cycle floating-point adder with a selectable approximate mode that
// discards low significand bits and truncates instead of rounding.
module apx_fp_adder_cfg
    import apx_fp_pkg::*;
#(
    parameter int EXP_W    = 8,
    parameter int MAN_W    = 23,
    parameter int APX_BITS = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [EXP_W+MAN_W:0]   input_a,
    input  logic                   input_a_stb,
    output logic                   input_a_ack,
    input  logic [EXP_W+MAN_W:0]   input_b,
    input  logic                   input_b_stb,
    output logic                   input_b_ack,
    input  logic                   apx_en,
    output logic [EXP_W+MAN_W:0]   output_z,
    output logic                   output_z_stb,
    input  logic                   output_z_ack
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;
    localparam int EXT_W = SIG_W + GRS_W;
    localparam int SUM_W = EXT_W + 1;
    localparam int XE_W  = EXP_W + 2;
    localparam int CNT_W = $clog2(EXT_W + 1);

    localparam logic [SIG_W-1:0]       APX_MASK = {SIG_W{1'b1}} << APX_BITS;
    localparam logic [W-1:0]           QNAN     = W'(canon_nan(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0]       EXP_ONES = {EXP_W{1'b1}};
    localparam logic signed [XE_W-1:0] EXP_MAX  = $signed({2'b00, EXP_ONES});
    localparam logic signed [XE_W-1:0] X_ONE    = $signed(XE_W'(1));

    fp_state_t state, next_state;

    logic [W-1:0]            a_reg, b_reg, z_reg;
    logic                    apx_q, big_sign, eff_sub, n_zero, n_sign;
    logic [SIG_W-1:0]        big_sig, small_sig;
    logic [EXP_W-1:0]        diff;
    logic signed [XE_W-1:0]  exp_r;
    logic [EXT_W-1:0]        big_ext, small_ext, norm_r;
    logic [SUM_W-1:0]        sum_r;

    logic                    sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big, special;
    logic [EXP_W-1:0]        ea, eb;
    logic [SIG_W-1:0]        sig_a, sig_b;
    logic [W-1:0]            special_z;
    logic [EXT_W-1:0]        ext_in, shifted, aligned, big_al, small_al;
    logic                    lost;
    logic [CNT_W-1:0]        lz;
    logic [EXT_W-1:0]        norm_next;
    logic signed [XE_W-1:0]  exp_next, exp_f;
    logic                    round_up;
    logic [SIG_W:0]          rounded;
    logic [MAN_W-1:0]        man_f;
    logic [W-1:0]            z_next;

    apx_lzc #(.WIDTH(EXT_W), .CNT_W(CNT_W)) u_lzc (
        .value(sum_r[EXT_W-1:0]),
        .count(lz)
    );

    assign output_z = z_reg;

    // State register; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (rst) state <= GET_A;
        else     state <= next_state;
    end

    // Next-state sequencing and handshake outputs decoded from the state
    always_comb begin
        next_state   = state;
        input_a_ack  = 1'b0;
        input_b_ack  = 1'b0;
        output_z_stb = 1'b0;
        case (state)
            GET_A: begin
                input_a_ack = !rst;
                if (input_a_stb) next_state = GET_B;
            end
            GET_B: begin
                input_b_ack = 1'b1;
                if (input_b_stb) next_state = UNPACK;
            end
            UNPACK:  next_state = special ? PUT_Z : ALIGN;
            ALIGN:   next_state = ADD;
            ADD:     next_state = NORM;
            NORM:    next_state = ROUND;
            ROUND:   next_state = PUT_Z;
            PUT_Z: begin
                output_z_stb = 1'b1;
                if (output_z_ack) next_state = GET_A;
            end
            default: next_state = GET_A;
        endcase
    end

    // Operand classification, special-case result and magnitude ordering
    always_comb begin
        sa     = a_reg[W-1];
        sb     = b_reg[W-1];
        ea     = a_reg[W-2:MAN_W];
        eb     = b_reg[W-2:MAN_W];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == EXP_ONES) && (a_reg[MAN_W-1:0] == '0);
        b_inf  = (eb == EXP_ONES) && (b_reg[MAN_W-1:0] == '0);
        a_nan  = (ea == EXP_ONES) && (a_reg[MAN_W-1:0] != '0);
        b_nan  = (eb == EXP_ONES) && (b_reg[MAN_W-1:0] != '0);
        sig_a  = a_zero ? '0 : {1'b1, a_reg[MAN_W-1:0]};
        sig_b  = b_zero ? '0 : {1'b1, b_reg[MAN_W-1:0]};
        a_big  = (ea > eb) || ((ea == eb) && (sig_a >= sig_b));
        special   = 1'b1;
        special_z = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) special_z = QNAN;
        else if (a_inf)                                       special_z = a_reg;
        else if (b_inf)                                       special_z = b_reg;
        else if (a_zero && b_zero)                            special_z = {sa & sb, {(W-1){1'b0}}};
        else                                                  special   = 1'b0;
    end

    // Barrel-align the smaller operand with sticky collection, then apply the approximation mask
    always_comb begin
        ext_in = {small_sig, {GRS_W{1'b0}}};
        if (int'(diff) >= EXT_W) begin
            shifted = '0;
            lost    = |small_sig;
        end else begin
            shifted = ext_in >> diff;
            lost    = |(ext_in & ~({EXT_W{1'b1}} << diff));
        end
        aligned = {shifted[EXT_W-1:1], shifted[0] | lost};
        if (apx_q) begin
            big_al   = {big_sig & APX_MASK, {GRS_W{1'b0}}};
            small_al = {aligned[EXT_W-1:GRS_W] & APX_MASK, {GRS_W{1'b0}}};
        end else begin
            big_al   = {big_sig, {GRS_W{1'b0}}};
            small_al = aligned;
        end
    end

    // Normalisation: one right shift on carry-out, otherwise a leading-zero left shift
    always_comb begin
        if (sum_r[SUM_W-1]) begin
            norm_next = {sum_r[SUM_W-1:2], sum_r[1] | sum_r[0]};
            exp_next  = exp_r + X_ONE;
        end else begin
            norm_next = sum_r[EXT_W-1:0] << lz;
            exp_next  = exp_r - $signed(XE_W'(lz));
        end
    end

    // Rounding (nearest-even or truncation) and final packing with overflow to infinity
    always_comb begin
        round_up = !apx_q && norm_r[2] && (norm_r[1] || norm_r[0] || norm_r[GRS_W]);
        rounded  = {1'b0, norm_r[EXT_W-1:GRS_W]} + (SIG_W+1)'(round_up);
        if (rounded[SIG_W]) begin
            man_f = rounded[MAN_W:1];
            exp_f = exp_r + X_ONE;
        end else begin
            man_f = rounded[MAN_W-1:0];
            exp_f = exp_r;
        end
        if (n_zero)                z_next = {n_sign, {(W-1){1'b0}}};
        else if (exp_f >= EXP_MAX) z_next = {n_sign, EXP_ONES, {MAN_W{1'b0}}};
        else                       z_next = {n_sign, exp_f[EXP_W-1:0], man_f};
    end

    // Datapath registers advanced one pipeline step per state
    always_ff @(posedge clk) begin
        if (rst) begin
            z_reg <= '0;
        end else begin
            case (state)
                GET_A: if (input_a_stb) a_reg <= input_a;
                GET_B: begin
                    if (input_b_stb) begin
                        b_reg <= input_b;
                        apx_q <= apx_en;
                    end
                end
                UNPACK: begin
                    big_sign  <= a_big ? sa : sb;
                    big_sig   <= a_big ? sig_a : sig_b;
                    small_sig <= a_big ? sig_b : sig_a;
                    diff      <= a_big ? (ea - eb) : (eb - ea);
                    exp_r     <= $signed({2'b00, a_big ? ea : eb});
                    eff_sub   <= sa ^ sb;
                    if (special) z_reg <= special_z;
                end
                ALIGN: begin
                    big_ext   <= big_al;
                    small_ext <= small_al;
                end
                ADD: begin
                    if (eff_sub) sum_r <= {1'b0, big_ext} - {1'b0, small_ext};
                    else         sum_r <= {1'b0, big_ext} + {1'b0, small_ext};
                end
                NORM: begin
                    norm_r <= norm_next;
                    exp_r  <= exp_next;
                    n_zero <= (sum_r == '0) || (exp_next < X_ONE);
                    n_sign <= (sum_r == '0) ? 1'b0 : big_sign;
                end
                ROUND: z_reg <= z_next;
                default: ;
            endcase
        end
    end

endmodule
